// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmit line among several requesters.
// Frames are start bit, DATA_W data bits LSB-first, then STOP_BITS stop bits, paced by baud_tick.
module uart_tx_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      baud_tick,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      tx,
    output logic                      busy,
    output logic [ID_W-1:0]           active_id
);

    localparam int CW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state, state_n;
    logic [DATA_W-1:0]   shreg, shreg_n;
    logic [CW-1:0]       bit_cnt, bit_cnt_n;
    logic                stop_cnt, stop_cnt_n;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_n;
    logic [ID_W-1:0]     active_id_n;
    logic [ID_W-1:0]     pick, cand;
    logic                found;
    logic                tx_n, busy_n;
    logic [NUM_REQ-1:0]  gnt_n;
    logic [DATA_W-1:0]   bytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign bytes[i] = data[i*DATA_W +: DATA_W];
    end

    // First requester after the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int o = 1; o <= NUM_REQ; o++) begin
            cand = ID_W'((int'(rr_ptr) + o) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        bit_cnt_n   = bit_cnt;
        stop_cnt_n  = stop_cnt;
        rr_ptr_n    = rr_ptr;
        active_id_n = active_id;
        tx_n        = tx;
        busy_n      = busy;
        gnt_n       = '0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    gnt_n[pick] = 1'b1;
                    shreg_n     = bytes[pick];
                    active_id_n = pick;
                    rr_ptr_n    = pick;
                    busy_n      = 1'b1;
                    state_n     = SYNC;
                end
            end
            SYNC: begin
                if (baud_tick) begin
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    tx_n      = shreg[0];
                    shreg_n   = shreg >> 1;
                    bit_cnt_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (bit_cnt == CW'(DATA_W - 1)) begin
                        tx_n       = 1'b1;
                        stop_cnt_n = 1'b0;
                        state_n    = STOP;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                        tx_n      = shreg[0];
                        shreg_n   = shreg >> 1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        busy_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            rr_ptr    <= ID_W'(NUM_REQ - 1);
            active_id <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
            gnt       <= '0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            stop_cnt  <= stop_cnt_n;
            rr_ptr    <= rr_ptr_n;
            active_id <= active_id_n;
            tx        <= tx_n;
            busy      <= busy_n;
            gnt       <= gnt_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized scoreboard bench for uart_tx_scheduler: a round-robin model predicts
// grant order and bytes, a monitor decodes tx frames tick by tick.
module tb_uart_tx_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int STOP_BITS = 1;
    localparam int ID_W      = 2;
    localparam int BUDGET    = 20000;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      baud_tick = 1'b0;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] data = '0;
    logic [NUM_REQ-1:0]        gnt;
    logic                      tx;
    logic                      busy;
    logic [ID_W-1:0]           active_id;

    uart_tx_scheduler #(
        .NUM_REQ(NUM_REQ),
        .DATA_W(DATA_W),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .baud_tick(baud_tick),
        .req(req),
        .data(data),
        .gnt(gnt),
        .tx(tx),
        .busy(busy),
        .active_id(active_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] val;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];
    int   tick_mode = 1;
    int   tick_cnt = 0;
    int   want[NUM_REQ];
    int   sent[NUM_REQ];
    logic [DATA_W-1:0] bytes_v[NUM_REQ][4];
    int   model_ptr = NUM_REQ - 1;
    bit   in_frame = 1'b0;
    int   tick_idx = 0;

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // baud_tick source: 0 = every 16 clk, 1 = random, 2 = frozen
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (tick_mode)
                0: begin
                    tick_cnt  = (tick_cnt + 1) % 16;
                    baud_tick = (tick_cnt == 0);
                end
                1: baud_tick = ($urandom_range(0, 5) == 0);
                default: baud_tick = 1'b0;
            endcase
        end
    end

    // requesters: on gnt, either present the next byte or drop req
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (gnt[i]) begin
                        sent[i]++;
                        if (sent[i] < want[i])
                            data[i*DATA_W +: DATA_W] = bytes_v[i][sent[i]];
                        else
                            req[i] = 1'b0;
                    end
                end
            end
        end
    end

    // monitor
    initial begin
        logic              prev_tx;
        logic [DATA_W-1:0] got;
        exp_t              cur;
        bit                tk;
        bit                rs;
        prev_tx = 1'b1;
        got     = '0;
        cur.id  = 0;
        cur.val = '0;
        forever begin
            @(posedge clk);
            tk = baud_tick;
            rs = rst;
            #1;
            if (!rs) begin
                check("rst_tx", int'(tx), 1);
                check("rst_busy", int'(busy), 0);
                check("rst_gnt", int'(gnt), 0);
                check("rst_active_id", int'(active_id), 0);
                in_frame = 1'b0;
                prev_tx  = 1'b1;
            end else begin
                if (gnt != '0) begin
                    check("gnt_onehot", $countones(gnt), 1);
                    if (exp_q.size() == 0) begin
                        check("gnt_unexpected", int'(gnt), 0);
                    end else begin
                        cur = exp_q.pop_front();
                        check("gnt_id", int'(gnt), 1 << cur.id);
                        check("active_id", int'(active_id), cur.id);
                        check("busy_on_gnt", int'(busy), 1);
                        check("tx_at_gnt", int'(tx), 1);
                        in_frame = 1'b1;
                        tick_idx = 0;
                        got      = '0;
                    end
                end else if (in_frame && tk) begin
                    tick_idx++;
                    if (tick_idx == 1) begin
                        check("start_bit", int'(tx), 0);
                    end else if (tick_idx <= DATA_W + 1) begin
                        got = {tx, got[DATA_W-1:1]};
                    end else if (tick_idx == DATA_W + 2) begin
                        check("stop_bit", int'(tx), 1);
                        check("frame_data", int'(got), int'(cur.val));
                    end
                    if (tick_idx == DATA_W + 2 + STOP_BITS) begin
                        check("busy_end", int'(busy), 0);
                        check("tx_idle", int'(tx), 1);
                        in_frame = 1'b0;
                    end else begin
                        check("busy_mid", int'(busy), 1);
                    end
                end else begin
                    check("tx_hold", int'(tx), int'(prev_tx));
                end
                prev_tx = tx;
            end
        end
    end

    // Reference: repeatedly grant the next pending requester after the last winner.
    task automatic start_round();
        int  left[NUM_REQ];
        int  k;
        bit  any;
        for (int i = 0; i < NUM_REQ; i++) left[i] = want[i];
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int o = 1; o <= NUM_REQ; o++) begin
                k = (model_ptr + o) % NUM_REQ;
                if (!any && left[k] > 0) begin
                    exp_q.push_back('{id: k, val: bytes_v[k][want[k] - left[k]]});
                    left[k]--;
                    model_ptr = k;
                    any = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            sent[i] = 0;
            if (want[i] > 0) begin
                data[i*DATA_W +: DATA_W] = bytes_v[i][0];
                req[i] = 1'b1;
            end
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || in_frame) && n < BUDGET) begin
            @(posedge clk);
            n++;
        end
        if (n >= BUDGET) begin
            total++;
            bad++;
            $display("FAIL %s: timeout with %0d grants outstanding", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_tick_idx(input int idx);
        int n;
        n = 0;
        while (!(in_frame && tick_idx >= idx) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("reach_tick", int'(n < BUDGET), 1);
    endtask

    task automatic set_want(input int w0, input int w1, input int w2, input int w3);
        want[0] = w0;
        want[1] = w1;
        want[2] = w2;
        want[3] = w3;
        for (int i = 0; i < NUM_REQ; i++)
            for (int j = 0; j < 4; j++)
                bytes_v[i][j] = DATA_W'($urandom);
    endtask

    initial begin
        for (int i = 0; i < NUM_REQ; i++) begin
            want[i] = 0;
            sent[i] = 0;
        end
        rst = 1'b0;
        tick_mode = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            req  = NUM_REQ'($urandom);
            data = (NUM_REQ*DATA_W)'($urandom);
        end
        req = '0;
        rst = 1'b1;
        tick_mode = 0;

        set_want(1, 0, 0, 0);
        bytes_v[0][0] = 8'hA5;
        start_round();
        wait_done("single_a5");

        set_want(2, 1, 1, 1);
        start_round();
        wait_done("all_four");

        set_want(0, 1, 0, 0);
        start_round();
        wait_done("req1_only");
        set_want(0, 1, 0, 1);
        start_round();
        wait_done("req1_req3");

        set_want(0, 0, 1, 0);
        start_round();
        wait_tick_idx(4);
        tick_mode = 2;
        repeat (200) @(posedge clk);
        tick_mode = 0;
        wait_done("freeze");

        set_want(1, 1, 0, 0);
        start_round();
        wait_tick_idx(6);
        rst = 1'b0;
        req = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_ptr = NUM_REQ - 1;
        set_want(0, 0, 0, 1);
        start_round();
        wait_done("after_reset");

        tick_mode = 1;
        repeat (20) begin
            set_want($urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3));
            if (want[0] + want[1] + want[2] + want[3] == 0)
                want[$urandom_range(0, NUM_REQ - 1)] = 1;
            start_round();
            wait_done("random_round");
        end

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
